// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter
//   Merges the pipeline write-back stream and a long-latency unit stream
//   (mult/div results, bus loads) onto the single register-file write port.
//   Write-back always wins. Long-latency writes that cannot issue directly
//   wait in a DEPTH-entry FIFO. Write-backs invalidate any queued writes to
//   the same register. Pending flags let decode stall on a queued target.
// Ports
//   clk, reset                     clock, async active-low reset
//   wb_we/wb_addr/wb_data/wb_pc    write-back stage request
//   md_req/md_addr/md_data/md_pc   long-latency request, md_ack = accepted
//   grf_we/grf_a3/grf_wd/grf_pc    register file write port
//   rd_a1/rd_a2 -> pend_a1/pend_a2 decode source regs with queued writes
//   q_full/q_busy                  queue full / queue holds a valid entry

// One queue slot: holds the write and does its own kill and hazard compares.
module grf_wq_entry (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic        clr,
  input  logic        kill_en,
  input  logic [4:0]  kill_addr,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic [31:0] in_pc,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        vld,
  output logic [4:0]  addr,
  output logic [31:0] data,
  output logic [31:0] pc,
  output logic        hit1,
  output logic        hit2
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld  <= 1'b0;
      addr <= '0;
      data <= '0;
      pc   <= '0;
    end else if (set) begin
      // A slot being written this edge is a newer write than the
      // write-back, so it is kept valid even on an address match.
      vld  <= 1'b1;
      addr <= in_addr;
      data <= in_data;
      pc   <= in_pc;
    end else if (clr || (kill_en && addr == kill_addr)) begin
      vld  <= 1'b0;
    end
  end

  assign hit1 = vld && (addr == rd_a1);
  assign hit2 = vld && (addr == rd_a2);
endmodule

module grf_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        md_req,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [31:0] md_pc,
  output logic        md_ack,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  output logic        pend_a1,
  output logic        pend_a2,
  output logic        q_full,
  output logic        q_busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  logic [DEPTH-1:0]       e_vld, e_set, e_clr, e_hit1, e_hit2;
  logic [DEPTH-1:0][4:0]  e_addr;
  logic [DEPTH-1:0][31:0] e_data, e_pc;

  logic wb_act, md_nz, q_empty, has_room, direct, enq, pop;

  assign wb_act   = wb_we && (wb_addr != 5'd0);
  assign md_nz    = md_req && (md_addr != 5'd0);
  assign q_empty  = (cnt == '0);
  // Room is judged on current occupancy only; a same-cycle pop does not count.
  assign has_room = (cnt < CW'(DEPTH));
  assign direct   = !wb_act && q_empty && md_nz;
  assign enq      = md_nz && has_room && !direct;
  // Idle write-back pops the head whether or not it was killed.
  assign pop      = !wb_act && !q_empty;

  assign md_ack = reset && md_req && ((md_addr == 5'd0) || has_room);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      assign e_set[i] = enq && (wr_ptr == PW'(i));
      assign e_clr[i] = pop && (rd_ptr == PW'(i));
      grf_wq_entry u_ent (
        .clk       (clk),
        .reset     (reset),
        .set       (e_set[i]),
        .clr       (e_clr[i]),
        .kill_en   (wb_act),
        .kill_addr (wb_addr),
        .in_addr   (md_addr),
        .in_data   (md_data),
        .in_pc     (md_pc),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .vld       (e_vld[i]),
        .addr      (e_addr[i]),
        .data      (e_data[i]),
        .pc        (e_pc[i]),
        .hit1      (e_hit1[i]),
        .hit2      (e_hit2[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (enq && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !enq) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = '0;
    grf_pc = '0;
    if (reset) begin
      if (wb_act) begin
        grf_we = 1'b1;
        grf_a3 = wb_addr;
        grf_wd = wb_data;
        grf_pc = wb_pc;
      end else if (direct) begin
        grf_we = 1'b1;
        grf_a3 = md_addr;
        grf_wd = md_data;
        grf_pc = md_pc;
      end else if (pop && e_vld[rd_ptr]) begin
        grf_we = 1'b1;
        grf_a3 = e_addr[rd_ptr];
        grf_wd = e_data[rd_ptr];
        grf_pc = e_pc[rd_ptr];
      end
    end
  end

  assign pend_a1 = reset && (rd_a1 != 5'd0) && (|e_hit1);
  assign pend_a2 = reset && (rd_a2 != 5'd0) && (|e_hit2);
  assign q_full  = reset && (cnt == CW'(DEPTH));
  assign q_busy  = reset && (|e_vld);
endmodule

// File: tb/tb_grf_write_arbiter.sv
module tb_grf_write_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we, md_req;
  logic [4:0]  wb_addr, md_addr, rd_a1, rd_a2, grf_a3;
  logic [31:0] wb_data, wb_pc, md_data, md_pc, grf_wd, grf_pc;
  logic        md_ack, grf_we, pend_a1, pend_a2, q_full, q_busy;

  int checks = 0;
  int failures = 0;

  grf_write_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_pc(wb_pc),
    .md_req(md_req), .md_addr(md_addr), .md_data(md_data), .md_pc(md_pc),
    .md_ack(md_ack),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .pend_a1(pend_a1), .pend_a2(pend_a2),
    .q_full(q_full), .q_busy(q_busy)
  );

  always #5 clk = ~clk;

  task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task tick;
    @(posedge clk);
    #1;
  endtask

  task wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we = we; wb_addr = a; wb_data = d; wb_pc = 32'h1000 + d;
  endtask

  task md(input logic rq, input logic [4:0] a, input logic [31:0] d);
    md_req = rq; md_addr = a; md_data = d; md_pc = 32'h2000 + d;
  endtask

  initial begin
    reset = 1'b0;
    wb(0, 0, 0); md(1, 5, 32'h55); rd_a1 = 0; rd_a2 = 0;
    // in reset: everything quiet, even with a request present
    #2;
    chk("rst_md_ack", md_ack, 0);
    chk("rst_grf_we", grf_we, 0);
    chk("rst_q_busy", q_busy, 0);
    chk("rst_q_full", q_full, 0);
    md(0, 0, 0);
    #6 reset = 1'b1;
    tick;

    // direct path
    md(1, 5, 32'hA5A5_0001); #1;
    chk("dir_ack", md_ack, 1);
    chk("dir_we", grf_we, 1);
    chk("dir_a3", grf_a3, 5);
    chk("dir_wd", grf_wd, 32'hA5A5_0001);
    chk("dir_pc", grf_pc, 32'h2000 + 32'hA5A5_0001);
    tick; md(0, 0, 0); #1;
    chk("dir_busy", q_busy, 0);
    chk("idle_we", grf_we, 0);
    chk("idle_a3", grf_a3, 0);

    // priority: wb r3 wins, md r7 queued then drained
    wb(1, 3, 32'h33); md(1, 7, 32'h77); rd_a1 = 7; #1;
    chk("pri_we", grf_we, 1);
    chk("pri_a3", grf_a3, 3);
    chk("pri_wd", grf_wd, 32'h33);
    chk("pri_ack", md_ack, 1);
    chk("pri_pend_pre", pend_a1, 0);
    tick; wb(0, 0, 0); md(0, 0, 0); #1;
    chk("pri_pend", pend_a1, 1);
    chk("pri_busy", q_busy, 1);
    chk("drain_we", grf_we, 1);
    chk("drain_a3", grf_a3, 7);
    chk("drain_wd", grf_wd, 32'h77);
    tick; #1;
    chk("pri_pend_post", pend_a1, 0);
    chk("pri_idle_we", grf_we, 0);
    chk("pri_idle_busy", q_busy, 0);

    // full: wb busy on r1, md 8, 9, 10
    rd_a1 = 0; rd_a2 = 9;
    wb(1, 1, 32'h11); md(1, 8, 32'h108); #1;
    chk("full_ack8", md_ack, 1);
    tick; md(1, 9, 32'h109); #1;
    chk("full_ack9", md_ack, 1);
    chk("full_nf", q_full, 0);
    tick; md(1, 10, 32'h10A); #1;
    chk("full_ack10", md_ack, 0);
    chk("full_full", q_full, 1);
    chk("full_pend9", pend_a2, 1);
    tick; #1;
    chk("full_hold", md_ack, 0);
    wb(0, 0, 0); #1;
    chk("full_d8_a3", grf_a3, 8);
    chk("full_d8_wd", grf_wd, 32'h108);
    chk("full_nopopr", md_ack, 0);
    tick; #1;
    chk("full_d9_a3", grf_a3, 9);
    chk("full_ack10b", md_ack, 1);
    tick; md(0, 0, 0); #1;
    chk("full_d10_a3", grf_a3, 10);
    chk("full_d10_we", grf_we, 1);
    chk("full_nf2", q_full, 0);
    chk("full_pend9_off", pend_a2, 0);
    tick; #1;
    chk("full_empty", q_busy, 0);
    chk("full_done_we", grf_we, 0);

    // kill: queued r4=1, then wb r4=2
    rd_a1 = 4; rd_a2 = 0;
    wb(1, 1, 32'h11); md(1, 4, 32'h1);
    tick; wb(1, 4, 32'h2); md(0, 0, 0); #1;
    chk("kill_wb_a3", grf_a3, 4);
    chk("kill_wb_wd", grf_wd, 2);
    chk("kill_pend_pre", pend_a1, 1);
    tick; wb(0, 0, 0); #1;
    chk("kill_we", grf_we, 0);
    chk("kill_wd", grf_wd, 0);
    chk("kill_busy", q_busy, 0);
    chk("kill_pend", pend_a1, 0);
    tick; md(1, 6, 32'h66); #1;
    // direct path again means the killed slot really popped
    chk("kill_popped", grf_a3, 6);
    tick; md(0, 0, 0);

    // zero address: acked, discarded
    md(1, 0, 32'hDEAD); #1;
    chk("zero_ack", md_ack, 1);
    chk("zero_we", grf_we, 0);
    tick; md(0, 0, 0); #1;
    chk("zero_busy", q_busy, 0);

    // reset mid-drain with two queued entries
    wb(1, 1, 32'h11); md(1, 11, 32'hB);
    tick; md(1, 12, 32'hC);
    tick; wb(0, 0, 0); md(0, 0, 0); #1;
    chk("rd_full", q_full, 1);
    chk("rd_a3", grf_a3, 11);
    #1 reset = 1'b0; #1;
    chk("rd_busy", q_busy, 0);
    chk("rd_we", grf_we, 0);
    chk("rd_full0", q_full, 0);
    tick;
    chk("rd_we_hold", grf_we, 0);
    #2 reset = 1'b1;
    tick; #1;
    chk("rd_lost_we", grf_we, 0);
    chk("rd_lost_busy", q_busy, 0);
    md(1, 13, 32'hD); #1;
    chk("rd_resume", grf_a3, 13);
    tick; md(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grf_write_arbiter.md
GRF_WRITE_ARBITER -- requirements
Module: grf_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set the number of pending-write queue entries; legal values are 2..8.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 wb_we  input  1  SHALL be the pipeline write-back stage write request.
REQ-005 wb_addr / wb_data / wb_pc  input  5 / 32 / 32  SHALL be the write-back target, data and instruction PC.
REQ-006 md_req  input  1  SHALL be the long-latency unit write request, for example mult/div result or bus load.
REQ-007 md_addr / md_data / md_pc  input  5 / 32 / 32  SHALL be the long-latency target, data and PC.
REQ-008 md_ack  output  1  SHALL indicate the md request is accepted this cycle.
REQ-009 grf_we / grf_a3 / grf_wd / grf_pc  output  1 / 5 / 32 / 32  SHALL drive the register file write port.
REQ-010 rd_a1 / rd_a2  input  5 / 5  SHALL be the decode-stage source register numbers.
REQ-011 pend_a1 / pend_a2  output  1 / 1  SHALL flag a queued write to rd_a1 / rd_a2.
REQ-012 q_full / q_busy  output  1 / 1  SHALL flag a full queue / a queue holding any valid entry.

Function
REQ-013 Write-back SHALL have absolute priority: if wb_we=1 and wb_addr!=0, the grf_* outputs SHALL equal wb_* combinationally in the same cycle.
REQ-014 The queue SHALL be a DEPTH-entry FIFO with wrapping read and write pointers. Each entry SHALL hold {valid, addr, data, pc}.
REQ-015 md_ack SHALL be 1 when md_req=1 and either md_addr=0 or occupancy<DEPTH. A pop in the same cycle SHALL NOT create room for the request.
REQ-016 An md request with md_addr=0 SHALL be acknowledged and discarded. It SHALL never reach the grf_* outputs or the queue.
REQ-017 Direct path: if the queue is empty, write-back is idle, and md_req=1 with md_addr!=0, the md write SHALL drive grf_* in the same cycle with md_ack=1 and SHALL NOT be enqueued.
REQ-018 Otherwise an acknowledged md request SHALL be enqueued at the next rising edge.
REQ-019 Drain: when write-back is idle and the head entry is valid, the head SHALL drive grf_* and be popped at the edge.
REQ-020 The queue SHALL drain one entry per idle cycle, in strict FIFO order.
REQ-021 Kill: when a write-back write to address X is granted, every queued entry with addr=X SHALL have valid cleared at that edge.
REQ-022 A killed entry at the head SHALL be popped in one cycle with grf_we=0.
REQ-023 pend_aN SHALL be 1 when rd_aN!=0 and any valid queue entry has addr=rd_aN. The decision SHALL be combinational.
REQ-024 An entry being enqueued SHALL NOT affect pend_aN until after the edge.
REQ-025 Simultaneous enqueue and pop SHALL keep occupancy unchanged and advance both pointers.
REQ-026 Occupancy SHALL never exceed DEPTH and SHALL never underflow.
REQ-027 q_full SHALL be 1 when occupancy=DEPTH.
REQ-028 q_busy SHALL be 1 when at least one valid entry exists.
REQ-029 When grf_we=0, grf_a3, grf_wd and grf_pc SHALL be 0.

Reset
REQ-030 On reset=0, at any time including mid-drain, pointers, occupancy and all valid bits SHALL clear immediately.
REQ-031 During reset, grf_we, md_ack, pend_a1, pend_a2, q_full and q_busy SHALL be 0.
REQ-032 Queued writes SHALL be lost on reset and never issued.
REQ-033 Normal operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-034 Direct path: queue empty, wb_we=0, md_req=1, md_addr=5, md_data=32'hA5A5_0001.
Required: same cycle md_ack=1, grf_we=1, grf_a3=5, grf_wd=32'hA5A5_0001; q_busy stays 0.
REQ-035 Priority/queue: md_req=1 (addr 7) while wb_we=1 (addr 3) for one cycle, then wb_we=0.
Required: cycle 0 writes r3; the next cycle writes r7 from the queue; pend_a1=1 with rd_a1=7 only between the two.
REQ-036 Full: DEPTH=2, wb_we=1 every cycle, md_req held with addresses 8, 9, 10.
Required: 8 and 9 are acked; 10 sees md_ack=0 and q_full=1.
After wb_we drops: writes 8, 9 in order; 10 is acked on the first cycle occupancy<2.
REQ-037 Kill: queue holds addr 4 (data 1), then wb writes addr 4 (data 2).
Required: the next idle cycle has grf_we=0 and the pop completes; r4 is never overwritten with 1.
REQ-038 Zero/reset: md_addr=0 sees md_ack=1 with no write. Asserting reset=0 mid-drain with 2 entries queued clears q_busy asynchronously with no further grf_we.
